// File: rtl/pwm_multi_channel_if.sv
// Control and output bundle of the multi-channel PWM generator.
// The master (register logic) drives the controls; the slave (PWM core) drives the outputs.
interface pwm_multi_channel_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      en;
  logic                      center;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      load;
  logic [CHANNELS-1:0]       pwm;
  logic                      period_end;
  logic                      upd_pending;

  modport master (
    output en, center, period, duty, load,
    input  pwm, period_end, upd_pending
  );

  modport slave (
    input  en, center, period, duty, load,
    output pwm, period_end, upd_pending
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared up / up-down period counter, per-channel duty compare,
// and pending/shadow register pairs so new settings only ever take effect on a period boundary.
module pwm_multi_channel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input logic                clk,
  input logic                rst,
  pwm_multi_channel_if.slave bus
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  dir_e                      dir_q, dir_d;
  logic [WIDTH-1:0]          sh_period_q, sh_period_d;
  logic [CHANNELS*WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic                      sh_center_q, sh_center_d;
  logic [WIDTH-1:0]          pend_period_q, pend_period_d;
  logic [CHANNELS*WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic                      pend_center_q, pend_center_d;
  logic                      pend_flag_q, pend_flag_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      period_end_q, period_end_d;
  logic                      boundary_s;
  logic                      apply_s;

  // Detect the last counter value of the current period.
  always_comb begin
    boundary_s = 1'b0;
    if (sh_center_q) begin
      // With P=1 the peak is also the final value, so it ends the period while still counting up.
      boundary_s = (sh_period_q == '0) ||
                   ((cnt_q == ONE) && ((dir_q == DIR_DOWN) || (sh_period_q == ONE)));
    end else begin
      boundary_s = (cnt_q >= sh_period_q);
    end
  end

  // Next-state logic for counter, direction, compare outputs and the register sets.
  always_comb begin
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    sh_period_d   = sh_period_q;
    sh_duty_d     = sh_duty_q;
    sh_center_d   = sh_center_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_center_d = pend_center_q;
    pend_flag_d   = pend_flag_q;
    period_end_d  = 1'b0;
    apply_s       = 1'b0;
    pwm_d         = '0;

    if (bus.load) begin
      pend_period_d = bus.period;
      pend_duty_d   = bus.duty;
      pend_center_d = bus.center;
      pend_flag_d   = 1'b1;
    end else begin
      pend_flag_d   = pend_flag_q;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = bus.en && (cnt_q < sh_duty_q[i*WIDTH +: WIDTH]);
    end

    if (!bus.en) begin
      cnt_d   = '0;
      dir_d   = DIR_UP;
      apply_s = 1'b1;
    end else if (boundary_s) begin
      cnt_d        = '0;
      dir_d        = DIR_UP;
      period_end_d = 1'b1;
      apply_s      = 1'b1;
    end else if (!sh_center_q) begin
      cnt_d = cnt_q + ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= sh_period_q) begin
        dir_d = DIR_DOWN;
        cnt_d = cnt_q - ONE;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end

    // A load in the same cycle as an apply bypasses the pending set.
    if (apply_s) begin
      if (bus.load) begin
        sh_period_d = bus.period;
        sh_duty_d   = bus.duty;
        sh_center_d = bus.center;
      end else if (pend_flag_q) begin
        sh_period_d = pend_period_q;
        sh_duty_d   = pend_duty_q;
        sh_center_d = pend_center_q;
      end else begin
        sh_period_d = sh_period_q;
      end
      pend_flag_d = 1'b0;
    end else begin
      sh_center_d = sh_center_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      dir_q         <= DIR_UP;
      sh_period_q   <= '0;
      sh_duty_q     <= '0;
      sh_center_q   <= 1'b0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_center_q <= 1'b0;
      pend_flag_q   <= 1'b0;
      pwm_q         <= '0;
      period_end_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      sh_period_q   <= sh_period_d;
      sh_duty_q     <= sh_duty_d;
      sh_center_q   <= sh_center_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_center_q <= pend_center_d;
      pend_flag_q   <= pend_flag_d;
      pwm_q         <= pwm_d;
      period_end_q  <= period_end_d;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.period_end  = period_end_q;
  assign bus.upd_pending = pend_flag_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus randomized traffic
// compared against a period-position reference model; a second 4-bit instance checks the width limit.
module tb_pwm_multi_channel;

  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.WIDTH(W), .CHANNELS(C)) bus ();
  pwm_multi_channel_if #(.WIDTH(4), .CHANNELS(1)) bus_s ();

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(C)) dut (.clk(clk), .rst(rst), .bus(bus));
  pwm_multi_channel #(.WIDTH(4), .CHANNELS(1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: position m_k inside the current period plus shadow/pending settings.
  int             m_k;
  int             m_shp, m_pp;
  logic [C*W-1:0] m_shd, m_pd;
  logic           m_shc, m_pc, m_flag;
  logic [C-1:0]   exp_pwm;
  logic           exp_pe;

  task automatic model_reset();
    m_k = 0; m_shp = 0; m_pp = 0; m_shd = '0; m_pd = '0;
    m_shc = 1'b0; m_pc = 1'b0; m_flag = 1'b0; exp_pwm = '0; exp_pe = 1'b0;
  endtask

  task automatic model_apply();
    if (bus.load) begin
      m_shp = int'(bus.period); m_shd = bus.duty; m_shc = bus.center;
    end else if (m_flag) begin
      m_shp = m_pp; m_shd = m_pd; m_shc = m_pc;
    end
    m_flag = 1'b0;
  endtask

  task automatic model_step();
    int len, c;
    if (!bus.en) begin
      exp_pwm = '0; exp_pe = 1'b0; m_k = 0;
      model_apply();
    end else begin
      if (m_shc) len = (m_shp == 0) ? 1 : 2 * m_shp;
      else       len = m_shp + 1;
      c = (m_k <= m_shp) ? m_k : 2 * m_shp - m_k;
      for (int i = 0; i < C; i++) exp_pwm[i] = (c < int'(m_shd[i*W +: W]));
      if (m_k == len - 1) begin
        exp_pe = 1'b1; m_k = 0;
        model_apply();
      end else begin
        exp_pe = 1'b0; m_k = m_k + 1;
        if (bus.load) m_flag = 1'b1;
      end
    end
    if (bus.load) begin
      m_pp = int'(bus.period); m_pd = bus.duty; m_pc = bus.center;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_load(input int p, input logic [C*W-1:0] d, input logic c);
    bus.period = W'(p); bus.duty = d; bus.center = c; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.pwm !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm got=%b want=0000", bus.pwm); end
    n_cmp++; if (bus.period_end !== 1'b0) begin n_fail++; $display("FAIL reset_pe got=%b want=0", bus.period_end); end
    n_cmp++; if (bus.upd_pending !== 1'b0) begin n_fail++; $display("FAIL reset_upd got=%b want=0", bus.upd_pending); end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.pwm !== 4'b0000 || bus.upd_pending !== 1'b0)
      begin n_fail++; $display("FAIL reset_release pwm=%b upd=%b want 0", bus.pwm, bus.upd_pending); end
  endtask

  task automatic test_edge_basic();
    int hi [C];
    int pe_cnt;
    pe_cnt = 0;
    for (int i = 0; i < C; i++) hi[i] = 0;
    bus.en = 1'b0;
    do_load(9, {8'd10, 8'd9, 8'd3, 8'd0}, 1'b0);
    bus.en = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      n_cmp++; if (bus.pwm !== exp_pwm) begin n_fail++; $display("FAIL edge_pwm t=%0d got=%b want=%b", t, bus.pwm, exp_pwm); end
      n_cmp++; if (bus.period_end !== (t % 10 == 0)) begin n_fail++; $display("FAIL edge_pe t=%0d got=%b want=%b", t, bus.period_end, (t % 10 == 0)); end
      if (t <= 10) begin
        for (int i = 0; i < C; i++) hi[i] += int'(bus.pwm[i]);
        pe_cnt += int'(bus.period_end);
      end
    end
    n_cmp++; if (hi[0] != 0)  begin n_fail++; $display("FAIL edge_hi0 got=%0d want=0", hi[0]); end
    n_cmp++; if (hi[1] != 3)  begin n_fail++; $display("FAIL edge_hi1 got=%0d want=3", hi[1]); end
    n_cmp++; if (hi[2] != 9)  begin n_fail++; $display("FAIL edge_hi2 got=%0d want=9", hi[2]); end
    n_cmp++; if (hi[3] != 10) begin n_fail++; $display("FAIL edge_hi3 got=%0d want=10", hi[3]); end
    n_cmp++; if (pe_cnt != 1) begin n_fail++; $display("FAIL edge_pe_count got=%0d want=1", pe_cnt); end
  endtask

  task automatic test_center();
    logic [7:0] pat;
    int ph;
    pat = 8'b1000_0011;
    bus.en = 1'b0;
    do_load(4, {8'd0, 8'd0, 8'd0, 8'd2}, 1'b1);
    bus.en = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      ph = (t - 1) % 8;
      n_cmp++; if (bus.pwm[0] !== pat[ph]) begin n_fail++; $display("FAIL center_pwm0 t=%0d got=%b want=%b", t, bus.pwm[0], pat[ph]); end
      n_cmp++; if (bus.period_end !== (ph == 7)) begin n_fail++; $display("FAIL center_pe t=%0d got=%b want=%b", t, bus.period_end, (ph == 7)); end
      n_cmp++; if (bus.pwm !== exp_pwm) begin n_fail++; $display("FAIL center_model t=%0d got=%b want=%b", t, bus.pwm, exp_pwm); end
    end
  endtask

  task automatic test_midperiod_update();
    int hi_old, hi_new;
    hi_old = 0; hi_new = 0;
    bus.en = 1'b0;
    do_load(9, {8'd0, 8'd0, 8'd0, 8'd3}, 1'b0);
    bus.en = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      if (t == 6) begin
        bus.duty = {8'd0, 8'd0, 8'd0, 8'd7}; bus.load = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      if (t <= 10) hi_old += int'(bus.pwm[0]);
      else         hi_new += int'(bus.pwm[0]);
      if (t >= 6 && t <= 10) begin
        n_cmp++; if (bus.upd_pending !== (t != 10)) begin n_fail++; $display("FAIL mid_upd t=%0d got=%b want=%b", t, bus.upd_pending, (t != 10)); end
      end
      n_cmp++; if (bus.pwm !== exp_pwm || bus.upd_pending !== m_flag)
        begin n_fail++; $display("FAIL mid_model t=%0d pwm=%b/%b upd=%b/%b", t, bus.pwm, exp_pwm, bus.upd_pending, m_flag); end
    end
    n_cmp++; if (hi_old != 3) begin n_fail++; $display("FAIL mid_old_high got=%0d want=3", hi_old); end
    n_cmp++; if (hi_new != 7) begin n_fail++; $display("FAIL mid_new_high got=%0d want=7", hi_new); end
  endtask

  task automatic test_multi_load();
    int hi_a, hi_b;
    hi_a = 0; hi_b = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 3)  begin bus.duty = {8'd0, 8'd0, 8'd0, 8'd2}; bus.load = 1'b1; end
      if (t == 6)  begin bus.duty = {8'd0, 8'd0, 8'd0, 8'd6}; bus.load = 1'b1; end
      if (t == 10) begin bus.duty = {8'd0, 8'd0, 8'd0, 8'd4}; bus.load = 1'b1; end
      tick();
      bus.load = 1'b0;
      if (t <= 10) hi_a += int'(bus.pwm[0]);
      else         hi_b += int'(bus.pwm[0]);
      if (t == 10) begin
        n_cmp++; if (bus.period_end !== 1'b1 || bus.upd_pending !== 1'b0)
          begin n_fail++; $display("FAIL multi_boundary pe=%b upd=%b want pe=1 upd=0", bus.period_end, bus.upd_pending); end
      end
      n_cmp++; if (bus.pwm !== exp_pwm || bus.period_end !== exp_pe)
        begin n_fail++; $display("FAIL multi_model t=%0d pwm=%b/%b pe=%b/%b", t, bus.pwm, exp_pwm, bus.period_end, exp_pe); end
    end
    n_cmp++; if (hi_a != 7) begin n_fail++; $display("FAIL multi_old_high got=%0d want=7", hi_a); end
    n_cmp++; if (hi_b != 4) begin n_fail++; $display("FAIL multi_new_high got=%0d want=4", hi_b); end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (bus.pwm[0] !== 1'b1 && guard < 20) begin tick(); guard++; end
    n_cmp++; if (bus.pwm[0] !== 1'b1) begin n_fail++; $display("FAIL arst_setup pwm0 got=%b want=1", bus.pwm[0]); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.pwm !== 4'b0000) begin n_fail++; $display("FAIL arst_pwm got=%b want=0000", bus.pwm); end
    n_cmp++; if (bus.period_end !== 1'b0) begin n_fail++; $display("FAIL arst_pe got=%b want=0", bus.period_end); end
    n_cmp++; if (bus.upd_pending !== 1'b0) begin n_fail++; $display("FAIL arst_upd got=%b want=0", bus.upd_pending); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_cmp++; if (bus.pwm !== 4'b0000 || bus.upd_pending !== 1'b0)
        begin n_fail++; $display("FAIL arst_after t=%0d pwm=%b upd=%b want 0", t, bus.pwm, bus.upd_pending); end
      n_cmp++; if (bus.period_end !== exp_pe) begin n_fail++; $display("FAIL arst_pe_model t=%0d got=%b want=%b", t, bus.period_end, exp_pe); end
    end
  endtask

  task automatic test_random();
    int p;
    logic [C*W-1:0] d;
    for (int t = 0; t < 600; t++) begin
      bus.en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 5) == 0) begin
        p = $urandom_range(0, 12);
        for (int i = 0; i < C; i++) d[i*W +: W] = W'($urandom_range(0, p + 2));
        bus.period = W'(p); bus.duty = d; bus.center = 1'($urandom_range(0, 1)); bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      tick();
      n_cmp++; if (bus.pwm !== exp_pwm) begin n_fail++; $display("FAIL rand_pwm t=%0d got=%b want=%b", t, bus.pwm, exp_pwm); end
      n_cmp++; if (bus.period_end !== exp_pe) begin n_fail++; $display("FAIL rand_pe t=%0d got=%b want=%b", t, bus.period_end, exp_pe); end
      n_cmp++; if (bus.upd_pending !== m_flag) begin n_fail++; $display("FAIL rand_upd t=%0d got=%b want=%b", t, bus.upd_pending, m_flag); end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_small_width();
    int ph, hi;
    hi = 0;
    bus_s.en = 1'b0; bus_s.center = 1'b0; bus_s.period = 4'd15; bus_s.duty = 4'd15; bus_s.load = 1'b1;
    tick();
    bus_s.load = 1'b0; bus_s.en = 1'b1;
    for (int t = 1; t <= 32; t++) begin
      tick();
      ph = (t - 1) % 16;
      if (t <= 16) hi += int'(bus_s.pwm[0]);
      n_cmp++; if (bus_s.pwm[0] !== (ph < 15)) begin n_fail++; $display("FAIL w4_pwm t=%0d got=%b want=%b", t, bus_s.pwm[0], (ph < 15)); end
      n_cmp++; if (bus_s.period_end !== (ph == 15)) begin n_fail++; $display("FAIL w4_pe t=%0d got=%b want=%b", t, bus_s.period_end, (ph == 15)); end
    end
    n_cmp++; if (hi != 15) begin n_fail++; $display("FAIL w4_high_count got=%0d want=15", hi); end
  endtask

  initial begin
    bus.en = 1'b0; bus.center = 1'b0; bus.period = '0; bus.duty = '0; bus.load = 1'b0;
    bus_s.en = 1'b0; bus_s.center = 1'b0; bus_s.period = '0; bus_s.duty = '0; bus_s.load = 1'b0;
    model_reset();
    test_reset();
    test_edge_basic();
    test_center();
    test_midperiod_update();
    test_multi_load();
    test_async_reset();
    test_random();
    test_small_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
